temp_sensor_sampler: RTL and testbench
======================================

Name: temp_sensor_sampler

Overview:
Initiator side of the parallel temperature-ADC interface.
- Generates the ADC conversion clock and a periodic start-of-conversion pulse.
- Waits for end-of-conversion, then latches the 8-bit parallel code and scales it to whole degrees C.
- Publishes the scaled value as a 32-bit word with a one-cycle valid strobe, for the seven-segment display path to consume.

Parameters:
CLK_DIV, 50, clkout half-period in clock cycles (clkout toggles every CLK_DIV cycles); legal range >= 1
SAMPLE_PERIOD, 1000000, clock cycles from one start pulse to the next (measured start-to-start)
START_CYCLES, 4, width of outSignal start pulse in clock cycles
SETTLE_CYCLES, 2, delay in clock cycles between synchronized EOC edge and data capture
TIMEOUT_CYCLES, 100000, maximum clock cycles spent in WAIT_EOC before abort
SCALE_MUL, 100, multiplier applied to the raw code
SCALE_SHIFT, 8, right shift applied after the multiply

Ports:
clock  in  1  system clock; all state on rising edge
reset  in  1  asynchronous, active-high reset
in0..in7  in  1 each  ADC parallel data, in0 = LSB; asynchronous to clock
clkin  in  1  ADC end-of-conversion, active high, asynchronous; 2-FF synchronized internally
clkout  out  1  ADC conversion clock, 50% duty
outSignal  out  1  start-of-conversion pulse, active high
data_out  out  32  scaled temperature, zero-extended, held between updates
data_valid  out  1  one-cycle strobe when data_out updates
timeout_err  out  1  sticky flag; set on EOC timeout, cleared by reset or next good capture

Behaviour:
Reset (asynchronous, immediate):
- clkout=0, outSignal=0, data_out=0, data_valid=0, timeout_err=0.
- FSM enters IDLE with the period counter at 0.
- Reset mid-conversion aborts the conversion; no capture, no strobe.

clkout:
- Free-running divider, independent of the FSM.
- Divider count wraps at CLK_DIV-1, then clkout toggles.
- First rising edge occurs CLK_DIV cycles after reset release.

EOC synchronizer:
- clkin passes through 2 flops, then an edge register.
- eoc_rise = sync & ~sync_d.

Period counter:
- Runs continuously; wraps at SAMPLE_PERIOD-1.
- The wrap produces a one-cycle start_tick.

FSM states:
- IDLE: on start_tick go to START. The first start_tick occurs SAMPLE_PERIOD cycles after reset release.
- START: outSignal=1 for exactly START_CYCLES cycles, then go to WAIT_EOC.
- WAIT_EOC: on eoc_rise go to SETTLE. If the cycle counter reaches TIMEOUT_CYCLES first, set timeout_err=1 and go to IDLE with no capture.
- SETTLE: count SETTLE_CYCLES cycles, then go to CAPTURE.
- CAPTURE (1 cycle): latch code = {in7..in0}, compute, write data_out, pulse data_valid=1, clear timeout_err, go to IDLE.

Arithmetic:
- product = code * SCALE_MUL, 16 bits unsigned (8x8; SCALE_MUL must be <= 255).
- result = product >> SCALE_SHIFT, truncated (no rounding).
- data_out = {zeros, result}.
- Default parameters: code 0 -> 0, 0xFF -> 99, 0x3B -> 23, 0x3D -> 23, 0x3E -> 24.

Boundary conditions:
- start_tick while not in IDLE: ignored. No queueing, no restart; the next start comes on the following wrap.
- eoc_rise outside WAIT_EOC: ignored.
- clkin already high when entering WAIT_EOC: no rising edge, so no capture; the FSM waits for high-low-high or times out.
- eoc_rise and timeout in the same cycle: eoc_rise wins; proceed to SETTLE.
- Latency, EOC pin rising to data_valid: 3 sync/edge cycles + SETTLE_CYCLES + 1 = 6 cycles at defaults. The bench checks this exact value.
- Requirement: SAMPLE_PERIOD > START_CYCLES + TIMEOUT_CYCLES + SETTLE_CYCLES + 2.

Decomposition:
Shared package temp_pkg holds:
- FSM state enum: IDLE, START, WAIT_EOC, SETTLE, CAPTURE.
- Data width constants: RAW_W=8, DATA_W=32.
- Default scale constants: SCALE_MUL, SCALE_SHIFT.

One sub-module, sync_edge_detect, contains the 2-FF synchronizer plus rising-edge detector for clkin. It is reusable by other async sensor inputs.

Everything else is inline: divider, period counter, FSM, scaler.

Test Plan:
- Bench parameters for all scenarios: CLK_DIV=2, SAMPLE_PERIOD=64, START_CYCLES=4, SETTLE_CYCLES=2, TIMEOUT_CYCLES=20.
- Reset and clkout: assert reset for 5 cycles then release -> all outputs 0 during reset; clkout period = 4 cycles, 50% duty; outSignal high for exactly 4 cycles beginning 64 cycles after release.
- Nominal capture: present in=0x3E, raise clkin 3 cycles after outSignal falls -> data_valid single pulse 6 cycles after the clkin edge; data_out=24; timeout_err=0.
- Scale extremes: in=0x00 -> data_out=0; in=0xFF -> data_out=99, upper 25 bits zero.
- Timeout: never raise clkin -> timeout_err=1 exactly 20 cycles after entering WAIT_EOC; no data_valid; data_out keeps its previous value. Next period with good EOC on in=0x3B -> data_out=23 and timeout_err clears in the same cycle as data_valid.
- Spurious and coincident events: pulse clkin during IDLE -> no capture. Hold clkin high across the start pulse -> no capture and timeout. EOC edge landing on the timeout cycle -> capture proceeds and timeout_err stays 0.
- Reset mid-operation: assert reset while in SETTLE -> outputs 0 immediately, no data_valid; after release the first start pulse occurs 64 cycles later.

Source files
------------

// File: rtl/temp_pkg.sv
// temp_pkg: shared state encoding, widths and scaling helpers
// for the temperature ADC sampler.
package temp_pkg;

  localparam int RAW_W = 8;
  localparam int DATA_W = 32;
  localparam int DEF_SCALE_MUL = 100;
  localparam int DEF_SCALE_SHIFT = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT_EOC,
    SETTLE,
    CAPTURE
  } state_t;

  function automatic int max3(int a, int b, int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // 8x8 unsigned multiply, then truncating right shift
  function automatic logic [2*RAW_W-1:0] scale(
    logic [RAW_W-1:0] code,
    logic [RAW_W-1:0] mul,
    int shift
  );
    logic [2*RAW_W-1:0] p;
    p = {{RAW_W{1'b0}}, code} * {{RAW_W{1'b0}}, mul};
    return p >> shift;
  endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// sync_edge_detect: 2-FF synchronizer with a rising-edge
// detector for an asynchronous single-bit input.
module sync_edge_detect (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_async,
  output logic o_rise
);

  logic r_meta;
  logic r_sync;
  logic r_sync_d;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_meta   <= 1'b0;
      r_sync   <= 1'b0;
      r_sync_d <= 1'b0;
    end else begin
      r_meta   <= i_async;
      r_sync   <= r_meta;
      r_sync_d <= r_sync;
    end
  end

  assign o_rise = r_sync & ~r_sync_d;

endmodule

// File: rtl/temp_sensor_sampler.sv
// temp_sensor_sampler: drives the parallel temperature ADC, captures
// each conversion and publishes it scaled to whole degrees C.
module temp_sensor_sampler
  import temp_pkg::*;
#(
  parameter int CLK_DIV        = 50,
  parameter int SAMPLE_PERIOD  = 1000000,
  parameter int START_CYCLES   = 4,
  parameter int SETTLE_CYCLES  = 2,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int SCALE_MUL      = DEF_SCALE_MUL,
  parameter int SCALE_SHIFT    = DEF_SCALE_SHIFT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in0,
  input  logic              in1,
  input  logic              in2,
  input  logic              in3,
  input  logic              in4,
  input  logic              in5,
  input  logic              in6,
  input  logic              in7,
  input  logic              clkin,
  output logic              clkout,
  output logic              outSignal,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              timeout_err
);

  localparam int DIV_W = $clog2(CLK_DIV + 1);
  localparam int PER_W = $clog2(SAMPLE_PERIOD + 1);
  localparam int CYC_W = $clog2(
    max3(START_CYCLES, SETTLE_CYCLES, TIMEOUT_CYCLES) + 1);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [PER_W-1:0] PER_LAST = PER_W'(SAMPLE_PERIOD - 1);
  localparam logic [CYC_W-1:0] START_LAST = CYC_W'(START_CYCLES - 1);
  localparam logic [CYC_W-1:0] SETTLE_LAST = CYC_W'(SETTLE_CYCLES - 1);
  localparam logic [CYC_W-1:0] TMO_LAST = CYC_W'(TIMEOUT_CYCLES - 1);

  logic [DIV_W-1:0]    r_div_cnt;
  logic                r_clkout;
  logic [PER_W-1:0]    r_per_cnt;
  state_t              r_state;
  state_t              w_state_nx;
  logic [CYC_W-1:0]    r_cyc;
  logic [CYC_W-1:0]    w_cyc_nx;
  logic [DATA_W-1:0]   r_data;
  logic                r_valid;
  logic                r_tmo;
  logic                w_start_tick;
  logic                w_eoc_rise;
  logic                w_capture;
  logic                w_timeout;
  logic [RAW_W-1:0]    w_code;
  logic [2*RAW_W-1:0]  w_result;

  sync_edge_detect u_eoc_sync (
    .i_clk   (clock),
    .i_rst   (reset),
    .i_async (clkin),
    .o_rise  (w_eoc_rise)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_div_cnt <= '0;
      r_clkout  <= 1'b0;
    end else if (r_div_cnt == DIV_LAST) begin
      r_div_cnt <= '0;
      r_clkout  <= ~r_clkout;
    end else begin
      r_div_cnt <= r_div_cnt + DIV_W'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_per_cnt <= '0;
    end else if (w_start_tick) begin
      r_per_cnt <= '0;
    end else begin
      r_per_cnt <= r_per_cnt + PER_W'(1);
    end
  end

  assign w_start_tick = (r_per_cnt == PER_LAST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_cyc   <= '0;
    end else begin
      r_state <= w_state_nx;
      r_cyc   <= w_cyc_nx;
    end
  end

  // eoc_rise is tested before the timeout so a coincident edge wins
  always_comb begin
    w_state_nx = r_state;
    w_cyc_nx   = r_cyc;
    w_capture  = 1'b0;
    w_timeout  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_start_tick) begin
          w_state_nx = START;
          w_cyc_nx   = '0;
        end
      end
      START: begin
        if (r_cyc == START_LAST) begin
          w_state_nx = WAIT_EOC;
          w_cyc_nx   = '0;
        end else begin
          w_cyc_nx = r_cyc + CYC_W'(1);
        end
      end
      WAIT_EOC: begin
        if (w_eoc_rise) begin
          w_state_nx = SETTLE;
          w_cyc_nx   = '0;
        end else if (r_cyc == TMO_LAST) begin
          w_state_nx = IDLE;
          w_cyc_nx   = '0;
          w_timeout  = 1'b1;
        end else begin
          w_cyc_nx = r_cyc + CYC_W'(1);
        end
      end
      SETTLE: begin
        if (r_cyc == SETTLE_LAST) begin
          w_state_nx = CAPTURE;
          w_cyc_nx   = '0;
        end else begin
          w_cyc_nx = r_cyc + CYC_W'(1);
        end
      end
      CAPTURE: begin
        w_capture  = 1'b1;
        w_state_nx = IDLE;
      end
      default: begin
        w_state_nx = IDLE;
        w_cyc_nx   = '0;
      end
    endcase
  end

  assign w_code = {in7, in6, in5, in4, in3, in2, in1, in0};
  assign w_result = scale(w_code, RAW_W'(SCALE_MUL), SCALE_SHIFT);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_tmo   <= 1'b0;
    end else begin
      r_valid <= w_capture;
      if (w_capture) begin
        r_data <= DATA_W'(w_result);
        r_tmo  <= 1'b0;
      end else if (w_timeout) begin
        r_tmo <= 1'b1;
      end
    end
  end

  assign clkout      = r_clkout;
  assign outSignal   = (r_state == START);
  assign data_out    = r_data;
  assign data_valid  = r_valid;
  assign timeout_err = r_tmo;

endmodule

// File: tb/tb_temp_sensor_sampler.sv
// Bench for temp_sensor_sampler: scoreboard of scaled captures fed
// by an arithmetic reference model, plus timing and boundary checks.
module tb_temp_sensor_sampler;

  localparam int CLK_DIV        = 2;
  localparam int SAMPLE_PERIOD  = 64;
  localparam int START_CYCLES   = 4;
  localparam int SETTLE_CYCLES  = 2;
  localparam int TIMEOUT_CYCLES = 20;
  localparam int SCALE_MUL      = 100;
  localparam int SCALE_SHIFT    = 8;
  localparam int LATENCY        = 3 + SETTLE_CYCLES + 1;

  typedef struct {
    logic [31:0] val;
    int          cyc;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  code_in = 8'h00;
  logic        clkin = 1'b0;
  logic        clkout;
  logic        outSignal;
  logic [31:0] data_out;
  logic        data_valid;
  logic        timeout_err;

  exp_t        q[$];
  exp_t        mon_e;
  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          rel = 0;
  logic [31:0] last_data = 32'd0;

  temp_sensor_sampler #(
    .CLK_DIV        (CLK_DIV),
    .SAMPLE_PERIOD  (SAMPLE_PERIOD),
    .START_CYCLES   (START_CYCLES),
    .SETTLE_CYCLES  (SETTLE_CYCLES),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .SCALE_MUL      (SCALE_MUL),
    .SCALE_SHIFT    (SCALE_SHIFT)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .in0         (code_in[0]),
    .in1         (code_in[1]),
    .in2         (code_in[2]),
    .in3         (code_in[3]),
    .in4         (code_in[4]),
    .in5         (code_in[5]),
    .in6         (code_in[6]),
    .in7         (code_in[7]),
    .clkin       (clkin),
    .clkout      (clkout),
    .outSignal   (outSignal),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .timeout_err (timeout_err)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [31:0] model(int code);
    return (code * SCALE_MUL) / (2 ** SCALE_SHIFT);
  endfunction

  task automatic check(string name, logic [31:0] act,
                       logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d",
               name, act, exp, cyc);
    end
  endtask

  task automatic tick(int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic check_reset_outputs();
    check("rst_clkout", clkout, 0);
    check("rst_outSignal", outSignal, 0);
    check("rst_data_out", data_out, 0);
    check("rst_data_valid", data_valid, 0);
    check("rst_timeout_err", timeout_err, 0);
  endtask

  // Returns on the first low cycle after the start pulse (WAIT_EOC).
  task automatic wait_start(output int s);
    bit seen;
    int w;
    seen = 0;
    s = cyc;
    for (int i = 0; i < 3 * SAMPLE_PERIOD; i++) begin
      @(negedge clock);
      if (outSignal === 1'b1) begin
        seen = 1;
        break;
      end
    end
    if (!seen) begin
      n_cmp++;
      n_err++;
      $display("FAIL start_seen: no start pulse by cycle %0d", cyc);
      return;
    end
    s = cyc;
    check("start_align", (s - rel) % SAMPLE_PERIOD, 0);
    w = 0;
    while (outSignal === 1'b1 && w < 10) begin
      w++;
      @(negedge clock);
    end
    check("start_width", w, START_CYCLES);
  endtask

  task automatic eoc(int code, int d, bit chk_to);
    exp_t e;
    tick(d);
    code_in = 8'(code);
    clkin = 1'b1;
    e.val = model(code);
    e.cyc = cyc + LATENCY;
    q.push_back(e);
    last_data = e.val;
    tick(LATENCY - 1);
    if (chk_to) check("timeout_sticky", timeout_err, 1);
    tick(3);
    clkin = 1'b0;
  endtask

  initial begin
    forever begin
      @(negedge clock);
      if (data_valid === 1'b1) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_valid: data_out=%0d at cycle %0d",
                   data_out, cyc);
        end else begin
          mon_e = q.pop_front();
          check("data_out", data_out, mon_e.val);
          check("latency", cyc, mon_e.cyc);
          check("tmo_clear", timeout_err, 0);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int s;
    reset = 1'b1;
    tick(5);
    check_reset_outputs();
    reset = 1'b0;
    rel = cyc;
    for (int k = 1; k < SAMPLE_PERIOD; k++) begin
      tick(1);
      check("clkout", clkout, (k / CLK_DIV) % 2);
      check("idle_no_start", outSignal, 0);
    end
    wait_start(s);
    check("first_start", s - rel, SAMPLE_PERIOD);

    eoc(8'h3E, 3, 0);
    check("nominal_value", data_out, 24);
    check("nominal_tmo", timeout_err, 0);

    wait_start(s);
    eoc(8'h00, 5, 0);
    wait_start(s);
    eoc(8'hFF, 7, 0);
    check("upper_zero", data_out >> 7, 0);

    wait_start(s);
    tick(TIMEOUT_CYCLES - 1);
    check("tmo_early", timeout_err, 0);
    tick(1);
    check("tmo_set", timeout_err, 1);
    check("tmo_hold", data_out, last_data);
    wait_start(s);
    eoc(8'h3B, 3, 1);

    clkin = 1'b1;
    tick(3);
    clkin = 1'b0;
    tick(4);

    clkin = 1'b1;
    wait_start(s);
    tick(TIMEOUT_CYCLES - 1);
    check("high_tmo_early", timeout_err, 0);
    tick(1);
    check("high_tmo_set", timeout_err, 1);
    check("high_hold", data_out, last_data);
    clkin = 1'b0;

    wait_start(s);
    eoc(8'h3D, TIMEOUT_CYCLES - 3, 1);
    tick(4);
    check("coinc_tmo", timeout_err, 0);

    wait_start(s);
    tick(2);
    code_in = 8'($urandom_range(0, 255));
    clkin = 1'b1;
    tick(3);
    reset = 1'b1;
    #1;
    check_reset_outputs();
    clkin = 1'b0;
    tick(3);
    reset = 1'b0;
    rel = cyc;
    last_data = 32'd0;
    wait_start(s);
    check("restart", s - rel, SAMPLE_PERIOD);
    check("restart_data", data_out, last_data);

    for (int i = 0; i < 8; i++) begin
      if (i > 0) wait_start(s);
      eoc(int'($urandom_range(0, 255)), int'($urandom_range(1, 12)), 0);
    end

    tick(10);
    check("pending", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
